// File: rtl/weight_sram_stream.sv
// Weight memory for the neuron array: single-cycle write port, one-cycle random read,
// a valid/ready burst streamer for fan-in weights, and a whole-array clear sequencer.
module weight_sram_stream #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic              bst_start,
  input  logic [ADDR_W-1:0] bst_base,
  input  logic [LEN_W-1:0]  bst_len,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BURST = 2'd2
  } state_t;

  // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_last/out_valid hold unchanged.

  logic [WIDTH-1:0]  mem [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] clr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;

  logic              adv;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  // The clear sequencer owns the write port; external writes are dropped meanwhile.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_q;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    adv = (state_q == BURST) && (!out_valid_q || out_ready) && (issued_q < len_q);
  end

  // Array is deliberately not reset; reads in the same edge see the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_q       <= '0;
      ptr_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_en) begin
            rd_data_q  <= mem[rd_addr];
            rd_valid_q <= 1'b1;
          end
          if (clr_start) begin
            state_q <= CLEAR;
            clr_q   <= '0;
          end else if (bst_start && (bst_len != '0)) begin
            state_q  <= BURST;
            ptr_q    <= bst_base;
            len_q    <= bst_len;
            issued_q <= '0;
          end
        end

        CLEAR: begin
          clr_q <= clr_q + ADDR_W'(1);
          if (clr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end

        BURST: begin
          if (adv) begin
            out_data_q  <= mem[ptr_q];
            out_valid_q <= 1'b1;
            out_last_q  <= (issued_q == len_q - LEN_W'(1));
            ptr_q       <= ptr_q + ADDR_W'(1);
            issued_q    <= issued_q + LEN_W'(1);
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_sram_stream.sv
// Directed bench for weight_sram_stream: expected reads and stream beats go into queues,
// and a negedge monitor pops and compares whenever the DUT presents data.
module tb_weight_sram_stream;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;
  localparam int SW     = WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              clr_start = 1'b0;
  logic              bst_start = 1'b0;
  logic [ADDR_W-1:0] bst_base = '0;
  logic [LEN_W-1:0]  bst_len = '0;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  weight_sram_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start),
    .bst_start(bst_start), .bst_base(bst_base), .bst_len(bst_len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] rd_exp_q[$];
  logic [SW-1:0]    st_exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int beats_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic          stall_prev = 1'b0;
  logic [SW-1:0] stall_beat = '0;
  logic          exp_done_next = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev    = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      if (exp_done_next) begin
        check("done_after_last", done, 1);
        exp_done_next = 1'b0;
      end
      if (done) check("done_rd_valid_excl", rd_valid, 0);
      if (rd_valid) begin
        if (rd_exp_q.size() > 0) check("rd_data", rd_data, rd_exp_q.pop_front());
        else check("rd_unexpected", rd_valid, 0);
      end
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_last, out_data}, stall_beat);
      end
      if (out_valid && out_ready) begin
        if (st_exp_q.size() > 0) check("beat", {out_last, out_data}, st_exp_q.pop_front());
        else check("beat_unexpected", out_valid, 0);
        beats_acc++;
        if (out_last) exp_done_next = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      stall_beat = {out_last, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    rd_exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    check("rd_valid_latency", rd_valid, 1);
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                           input logic [3:0] pat, input int exp_cycles);
    logic [ADDR_W-1:0] a;
    logic [SW-1:0]     e;
    int cyc;
    int beats0;
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_W'(i);
      e = {1'b0, WIDTH'(a)};
      e[SW-1] = (i == int'(len) - 1);
      st_exp_q.push_back(e);
    end
    beats0 = beats_acc;
    bst_base = base; bst_len = len; bst_start = 1'b1;
    tick();
    bst_start = 1'b0;
    check("burst_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < 200) begin
      out_ready = pat[cyc % 4];
      tick();
      cyc++;
    end
    check("burst_done", done, 1);
    if (exp_cycles >= 0) check("burst_cycles", cyc, exp_cycles);
    check("burst_beats", beats_acc - beats0, len);
    check("burst_idle", busy, 0);
    check("burst_valid_low", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int guard;
    logic signed [WIDTH-1:0] sv;

    // Reset values
    repeat (2) tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outputs", {rd_data, out_data, out_last}, 0);
    rst = 1'b0;
    tick();

    // Whole-array clear: busy for exactly DEPTH cycles, done at the DEPTH-th edge
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0; guard = 0;
    while (!done && guard < 1000) begin
      if (busy) cnt++;
      tick();
      guard++;
    end
    check("clr_busy_cycles", cnt, 256);
    check("clr_done", done, 1);
    check("clr_idle", busy, 0);
    tick();
    check("clr_done_pulse", done, 0);
    do_read(8'd0, 32'd0);
    do_read(8'd128, 32'd0);
    do_read(8'd255, 32'd0);

    // Read-first on a simultaneous read/write to the same address
    sv = -3; do_write(8'd5, sv);
    do_write(8'd6, 32'd7);
    sv = -3;
    rd_en = 1'b1; rd_addr = 8'd5;
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'd9;
    rd_exp_q.push_back(sv);
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_rd_valid", rd_valid, 1);
    do_read(8'd5, 32'd9);
    do_read(8'd6, 32'd7);

    // Load mem[i] = i and stream
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), WIDTH'(i));
    run_burst(8'd4, 9'd4, 4'b1111, 5);
    run_burst(8'd4, 9'd4, 4'b1001, -1);
    run_burst(8'd254, 9'd4, 4'b1111, 5);

    // Zero-length burst is ignored
    out_ready = 1'b1;
    bst_base = 8'd3; bst_len = 9'd0; bst_start = 1'b1;
    tick();
    bst_start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_done", done, 0);
    tick();
    check("len0_done_later", done, 0);

    // Reset in the middle of a burst after two accepted beats
    sv = -100;
    do_write(8'd10, 32'h1234_5678);
    do_write(8'd11, sv);
    st_exp_q.push_back({1'b0, 32'd8});
    st_exp_q.push_back({1'b0, 32'd9});
    out_ready = 1'b1;
    bst_base = 8'd8; bst_len = 9'd8; bst_start = 1'b1;
    tick();
    bst_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();
    do_read(8'd10, 32'h1234_5678);
    do_read(8'd11, sv);
    do_read(8'd9, 32'd9);
    tick();

    check("rd_queue_empty", rd_exp_q.size(), 0);
    check("stream_queue_empty", st_exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_sram_stream.md
Name: weight_sram_stream

Overview:
- Parametrised synchronous weight memory for the neuron array.
- Provides a single-cycle write port and a one-cycle-latency random read port.
- Provides a burst streamer that delivers a neuron's fan-in weights over a valid/ready handshake into the accumulate datapath.
- Provides a hardware clear sequencer that zeroes the whole array after power-up or between network loads.

Parameters:
- WIDTH, 32, bits per signed weight.
- DEPTH, 256, number of weight words.
- ADDR_W, $clog2(DEPTH), address width.
- LEN_W, ADDR_W+1, burst length width; allows len = DEPTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  signed write data.
- rd_en  in  1  random-read strobe.
- rd_addr  in  ADDR_W  random-read address.
- rd_data  out  WIDTH  signed random-read data.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- clr_start  in  1  start whole-array clear.
- bst_start  in  1  start burst.
- bst_base  in  ADDR_W  first burst address.
- bst_len  in  LEN_W  number of beats.
- out_data  out  WIDTH  signed stream data.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  final beat of burst; qualified by out_valid.
- busy  out  1  high in CLEAR or BURST.
- done  out  1  one-cycle pulse when CLEAR or BURST completes.

Behaviour:
- Reset, asserted asynchronously: state=IDLE; rd_data=0, rd_valid=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; all internal counters are zeroed.
- Memory array is never reset. A reset during CLEAR leaves the array partially cleared.
- FSM states are IDLE, CLEAR and BURST. busy = (state != IDLE).
- IDLE:
  - clr_start has priority over bst_start → CLEAR with counter=0.
  - Otherwise bst_start with bst_len != 0 → BURST; latch base and len.
  - bst_start with bst_len == 0 is ignored: no state change, no done.
  - Starts raised while busy are ignored.
- CLEAR: write 0 to mem[counter] every cycle; counter increments. After writing DEPTH-1, assert done for one cycle and return to IDLE. CLEAR takes exactly DEPTH cycles.
- Writes:
  - wr_en is honoured in IDLE and BURST; mem[wr_addr] <= wr_data on the edge.
  - wr_en is ignored during CLEAR.
- Random read:
  - rd_en is honoured only in IDLE. rd_data <= mem[rd_addr] and rd_valid=1 on the next cycle.
  - rd_en in CLEAR or BURST is dropped and rd_valid stays 0.
  - rd_data holds its last value when rd_valid=0.
  - Read-first semantics: a read and a write to the same address in the same cycle return the old contents.
- BURST:
  - Read pointer starts at base. The address wraps modulo DEPTH, so base+i uses ADDR_W-bit arithmetic.
  - Advance condition: adv = (!out_valid || out_ready) && beats_issued < len.
  - On adv, out_data <= mem[ptr], out_valid <= 1 and ptr++. out_last <= 1 when this is beat len-1.
  - If out_valid && !out_ready, then out_data, out_valid and out_last hold stable.
  - If out_valid && out_ready && no beat remains to issue, out_valid <= 0.
  - Back-to-back throughput is 1 beat/cycle while out_ready=1. First out_valid appears 1 cycle after bst_start is accepted.
  - When the last beat is accepted (out_valid && out_ready && out_last): done pulses for one cycle on the next edge, state returns to IDLE and out_valid=0.
  - A write during BURST to an address not yet read is visible in the stream. A write to the address being read that cycle yields the old data.
- done is never asserted for ignored starts. done and rd_valid are never high together.

Test Plan:
- Reset, then clr_start (DEPTH=256) → busy for 256 cycles; done at cycle 256; random reads of addr 0, 128 and 255 each return 0 with rd_valid one cycle after rd_en.
- Write mem[5]=-3 and mem[6]=7; then rd_en addr 5 and, in the same cycle, wr_en addr 5 data 9 → rd_data=-3. The next read of addr 5 returns 9.
- Load mem[i]=i; bst_base=4, bst_len=4, out_ready=1 → beats 4,5,6,7 on consecutive cycles; out_last only on 7; done one cycle after the last beat is accepted.
- Same burst with out_ready toggling 1,0,0,1,... → no beat lost or duplicated; out_data stable while stalled; 4 accepted beats total.
- bst_base=254, bst_len=4 → beats 254,255,0,1. A separate burst with bst_len=0 → no busy and no done.
- Assert rst mid-BURST after 2 beats → out_valid=0, busy=0 immediately; after reset, reading the written addresses returns the pre-reset contents.
